// File: rtl/drv_switch_scan.sv
// Row-scanning sequencer for a switch matrix: drives one row at a time,
// lets the columns settle, samples them and builds a per-key level image.
// Ports:
//   i_clk, i_rst (async, active-low), i_en (scan enable)
//   i_col     : raw column lines, asynchronous to i_clk
//   o_row     : row drive, one bit at the active level while scanning
//   o_row_idx : index of the row currently driven
//   o_drv_sw  : key level image, [row][col], in i_col polarity
//   o_frame   : one-cycle pulse when the last row of a frame is visible
module drv_switch_scan #(
  parameter int p_line   = 4,
  parameter int p_column = 4,
  parameter int p_settle = 4,
  parameter int p_mode   = 0
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_en,
  input  logic [p_column-1:0]       i_col,
  output logic [p_line-1:0]         o_row,
  output logic [$clog2(p_line)-1:0] o_row_idx,
  output logic [p_column-1:0]       o_drv_sw [p_line-1:0],
  output logic                      o_frame
);

  localparam int   IW  = $clog2(p_line);
  localparam int   CW  = $clog2(p_settle);
  localparam logic ACT = (p_mode != 0);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [CW-1:0]       cnt;
  logic [IW-1:0]       idx;
  logic [p_column-1:0] col_s1;
  logic [p_column-1:0] col_s2;
  logic                cnt_last;
  logic                row_last;
  logic                capture;

  assign cnt_last = (cnt == CW'(p_settle - 1));
  assign row_last = (idx == IW'(p_line - 1));
  // A disable seen in SAMPLE suppresses the capture.
  assign capture  = (state == SAMPLE) && i_en;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    if (!i_en) begin
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE:    state_nx = SETTLE;
        SETTLE:  if (cnt_last) state_nx = SAMPLE;
        SAMPLE:  state_nx = SETTLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    o_row = {p_line{~ACT}};
    if (state != IDLE) begin
      o_row[idx] = ACT;
    end
  end

  assign o_row_idx = idx;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      col_s1  <= {p_column{~ACT}};
      col_s2  <= {p_column{~ACT}};
      cnt     <= '0;
      idx     <= '0;
      o_frame <= 1'b0;
      for (int r = 0; r < p_line; r++) begin
        o_drv_sw[r] <= {p_column{~ACT}};
      end
    end else begin
      col_s1  <= i_col;
      col_s2  <= col_s1;
      o_frame <= capture && row_last;
      if (state == SETTLE && state_nx == SETTLE) begin
        cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
      end
      // Leaving the scan always restarts at row 0.
      if (!i_en) begin
        idx <= '0;
      end else if (capture) begin
        idx <= row_last ? '0 : idx + 1'b1;
      end
      if (capture) begin
        o_drv_sw[idx] <= col_s2;
      end
    end
  end

endmodule

// File: tb/tb_drv_switch_scan.sv
// Self-checking bench for drv_switch_scan: a key-matrix model drives the
// columns, and a cycle-count scan model predicts rows, frames and image.
module tb_drv_switch_scan;

  localparam int L = 4;
  localparam int C = 4;
  localparam int S = 4;
  localparam int P = S + 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic [C-1:0] col;
  logic [L-1:0] row;
  logic [1:0]   row_idx;
  logic [C-1:0] img [L-1:0];
  logic         frame;

  logic         en2 = 1'b0;
  logic [C-1:0] col2;
  logic [L-1:0] row2;
  logic [1:0]   idx2;
  logic [C-1:0] img2 [L-1:0];
  logic         frame2;

  logic [C-1:0] keys  [L];
  logic [C-1:0] keys2 [L];

  bit           scanning;
  int           n;
  logic [C-1:0] exp_img [L];
  logic         exp_frame;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  drv_switch_scan #(
    .p_line(L), .p_column(C), .p_settle(S), .p_mode(0)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_col(col),
    .o_row(row), .o_row_idx(row_idx), .o_drv_sw(img), .o_frame(frame)
  );

  drv_switch_scan #(
    .p_line(L), .p_column(C), .p_settle(S), .p_mode(1)
  ) dut_pd (
    .i_clk(clk), .i_rst(rst), .i_en(en2), .i_col(col2),
    .o_row(row2), .o_row_idx(idx2), .o_drv_sw(img2), .o_frame(frame2)
  );

  // Physical matrix: a pressed key ties its column to the driven row level.
  always_comb begin
    col = '1;
    for (int r = 0; r < L; r++)
      for (int c = 0; c < C; c++)
        if (!row[r] && keys[r][c]) col[c] = 1'b0;
  end

  always_comb begin
    col2 = '0;
    for (int r = 0; r < L; r++)
      for (int c = 0; c < C; c++)
        if (row2[r] && keys2[r][c]) col2[c] = 1'b1;
  end

  function automatic logic [L-1:0] exp_row();
    logic [L-1:0] v;
    v = '1;
    if (scanning) v[(n / P) % L] = 1'b0;
    return v;
  endfunction

  function automatic logic [1:0] exp_idx();
    return scanning ? 2'((n / P) % L) : 2'd0;
  endfunction

  // Advance one clock and update the scan model from the inputs at the edge.
  task automatic step();
    @(posedge clk);
    exp_frame = 1'b0;
    if (!rst || !en) begin
      scanning = 1'b0;
    end else if (!scanning) begin
      scanning = 1'b1;
      n = 0;
    end else begin
      if (n % P == S) begin
        exp_img[(n / P) % L] = ~keys[(n / P) % L];
        if ((n / P) % L == L - 1) exp_frame = 1'b1;
      end
      n++;
    end
    #1;
  endtask

  task automatic model_reset();
    scanning = 1'b0;
    n = 0;
    exp_frame = 1'b0;
    for (int r = 0; r < L; r++) exp_img[r] = '1;
  endtask

  task automatic test_reset();
    for (int r = 0; r < L; r++) begin
      keys[r] = '0;
      keys2[r] = '0;
    end
    #2 rst = 1'b0;
    #1;
    model_reset();
    checks++;
    if (row !== 4'b1111 || frame !== 1'b0 || row_idx !== 2'd0) begin
      errors++;
      $display("FAIL reset_out row=%b frame=%b idx=%0d req 1111/0/0",
               row, frame, row_idx);
    end
    for (int r = 0; r < L; r++) begin
      checks++;
      if (img[r] !== 4'b1111) begin
        errors++;
        $display("FAIL reset_img r=%0d got %b req 1111", r, img[r]);
      end
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (8) begin
      step();
      checks++;
      if (row !== 4'b1111 || frame !== 1'b0 || img[1] !== 4'b1111) begin
        errors++;
        $display("FAIL idle row=%b frame=%b img1=%b req 1111/0/1111",
                 row, frame, img[1]);
      end
    end
  endtask

  task automatic test_scan();
    int frames;
    frames = 0;
    en = 1'b1;
    repeat (45) begin
      step();
      if (frame) frames++;
      checks++;
      if (row !== exp_row() || row_idx !== exp_idx()
          || frame !== exp_frame) begin
        errors++;
        $display("FAIL scan n=%0d row=%b idx=%0d frame=%b req %b/%0d/%b",
                 n, row, row_idx, frame, exp_row(), exp_idx(), exp_frame);
      end
    end
    checks++;
    if (frames != 2) begin
      errors++;
      $display("FAIL frame_count got %0d req 2", frames);
    end
    en = 1'b0;
    step();
    checks++;
    if (row !== 4'b1111) begin
      errors++;
      $display("FAIL scan_stop row=%b req 1111", row);
    end
  endtask

  task automatic test_single_key();
    keys[2] = 4'b0010;
    en = 1'b1;
    repeat (21) begin
      step();
      for (int r = 0; r < L; r++) begin
        checks++;
        if (img[r] !== exp_img[r]) begin
          errors++;
          $display("FAIL key_img n=%0d r=%0d got %b req %b",
                   n, r, img[r], exp_img[r]);
        end
      end
    end
    checks++;
    if (img[2] !== 4'b1101 || img[0] !== 4'b1111 || img[3] !== 4'b1111) begin
      errors++;
      $display("FAIL key_press img2=%b img0=%b img3=%b req 1101/1111/1111",
               img[2], img[0], img[3]);
    end
    keys[2] = 4'b0000;
    repeat (20) begin
      step();
      checks++;
      if (img[2] !== exp_img[2] || frame !== exp_frame) begin
        errors++;
        $display("FAIL key_rel n=%0d img2=%b frame=%b req %b/%b",
                 n, img[2], frame, exp_img[2], exp_frame);
      end
    end
    checks++;
    if (img[2] !== 4'b1111) begin
      errors++;
      $display("FAIL key_release img2=%b req 1111", img[2]);
    end
  endtask

  task automatic test_disable();
    en = 1'b0;
    repeat (2) step();
    keys[1] = 4'b0001;
    en = 1'b1;
    repeat (10) step();
    en = 1'b0;
    step();
    checks++;
    if (row !== 4'b1111 || frame !== 1'b0 || img[1] !== 4'b1111
        || img[1] !== exp_img[1]) begin
      errors++;
      $display("FAIL dis_sample row=%b frame=%b img1=%b req 1111/0/%b",
               row, frame, img[1], exp_img[1]);
    end
    repeat (3) step();
    en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (row !== exp_row() || img[1] !== exp_img[1]) begin
        errors++;
        $display("FAIL reen i=%0d row=%b img1=%b req %b/%b",
                 i, row, img[1], exp_row(), exp_img[1]);
      end
    end
    checks++;
    if (row !== 4'b1101) begin
      errors++;
      $display("FAIL reen_row1 row=%b req 1101", row);
    end
    keys[1] = 4'b0000;
  endtask

  task automatic test_async_reset();
    en = 1'b0;
    step();
    keys[0] = 4'b1000;
    keys[3] = 4'b0100;
    en = 1'b1;
    while (!(scanning && n == 36)) step();
    checks++;
    if (img[3] !== 4'b1011 || row !== 4'b0111) begin
      errors++;
      $display("FAIL pre_rst img3=%b row=%b req 1011/0111", img[3], row);
    end
    rst = 1'b0;
    #2;
    model_reset();
    checks++;
    if (row !== 4'b1111 || row_idx !== 2'd0 || frame !== 1'b0
        || img[0] !== 4'b1111 || img[3] !== 4'b1111) begin
      errors++;
      $display("FAIL async_rst row=%b idx=%0d img0=%b img3=%b",
               row, row_idx, img[0], img[3]);
    end
    rst = 1'b1;
    repeat (20) begin
      step();
      checks++;
      if (row !== exp_row() || frame !== exp_frame
          || img[0] !== exp_img[0]) begin
        errors++;
        $display("FAIL post_rst n=%0d row=%b img0=%b req %b/%b",
                 n, row, img[0], exp_row(), exp_img[0]);
      end
    end
    keys[0] = '0;
    keys[3] = '0;
  endtask

  task automatic test_random();
    en = 1'b0;
    step();
    en = 1'b1;
    step();
    for (int it = 0; it < 4; it++) begin
      for (int r = 0; r < L; r++) keys[r] = C'($urandom);
      repeat (20) begin
        step();
        checks++;
        if (row !== exp_row() || row_idx !== exp_idx()
            || frame !== exp_frame) begin
          errors++;
          $display("FAIL rnd_ctl n=%0d row=%b frame=%b req %b/%b",
                   n, row, frame, exp_row(), exp_frame);
        end
        for (int r = 0; r < L; r++) begin
          checks++;
          if (img[r] !== exp_img[r]) begin
            errors++;
            $display("FAIL rnd_img n=%0d r=%0d got %b req %b",
                     n, r, img[r], exp_img[r]);
          end
        end
      end
    end
    en = 1'b0;
    step();
  endtask

  task automatic test_pulldown();
    checks++;
    if (row2 !== 4'b0000 || img2[0] !== 4'b0000) begin
      errors++;
      $display("FAIL pd_idle row=%b img0=%b req 0000/0000", row2, img2[0]);
    end
    keys2[0] = 4'b1000;
    en2 = 1'b1;
    step();
    checks++;
    if (row2 !== 4'b0001) begin
      errors++;
      $display("FAIL pd_row row=%b req 0001", row2);
    end
    repeat (20) step();
    checks++;
    if (img2[0] !== 4'b1000 || img2[1] !== 4'b0000 || frame2 !== 1'b1) begin
      errors++;
      $display("FAIL pd_img img0=%b img1=%b frame=%b req 1000/0000/1",
               img2[0], img2[1], frame2);
    end
    en2 = 1'b0;
    step();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_scan();
    test_single_key();
    test_disable();
    test_async_reset();
    test_random();
    test_pulldown();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/drv_switch_scan.md
# drv_switch_scan

Row-scanning sequencer for a physical switch matrix. Drives one row line active at a time, waits for the column lines to settle, samples them and accumulates a full per-key level image. The image is the `i_drv_sw` input of the matrix switch driver (debounce/edge/toggle stage), so the driver can be fed from a `p_line + p_column` pin matrix instead of one pin per key.

## Interface
Parameters:
- `p_line`, 4: number of matrix rows (driven lines), ≥2.
- `p_column`, 4: number of matrix columns (sensed lines), ≥1.
- `p_settle`, 4: cycles a row is driven before its columns are sampled, ≥3 (covers the 2-FF synchronizer).
- `p_mode`, 0: 0 = PULLUP (active level 0), 1 = PULLDOWN (active level 1). Same encoding as the switch drivers.

Ports:
- `i_clk` in 1: system clock.
- `i_rst` in 1: reset, asynchronous, active-low.
- `i_en` in 1: scan enable, level.
- `i_col` in `[p_column-1:0]`: raw column lines, asynchronous to `i_clk`.
- `o_row` out `[p_line-1:0]`: row drive; exactly one bit at active level while scanning.
- `o_row_idx` out `[$clog2(p_line)-1:0]`: index of the row currently driven.
- `o_drv_sw` out `[p_column-1:0]`, unpacked `[p_line-1:0]`: key level image. Element `[r][c]` is the last sampled level of column `c` with row `r` driven, in `i_col` polarity.
- `o_frame` out 1: one-cycle pulse when the last row of a full scan has been captured.

## Operation
- Active level A = 0 for PULLUP, 1 for PULLDOWN; released level R = ~A.
- `i_col` passes a 2-stage synchronizer; only synchronized values are sampled.
- FSM states:
  - IDLE: all `o_row` = R; `o_row_idx` = 0; settle counter = 0. Leaves to SETTLE when `i_en` = 1.
  - SETTLE: `o_row[o_row_idx]` = A and all other rows = R. Counter counts 0..p_settle-1. Goes to SAMPLE when the counter = p_settle-1.
  - SAMPLE (one cycle):
    - Captures the synchronized columns into `o_drv_sw[o_row_idx]`; the update is visible the next cycle.
    - Advances `o_row_idx`, wrapping `p_line-1` → 0. On the wrap, pulses `o_frame` in the following cycle.
    - Returns to SETTLE with the counter cleared.
- `i_en` = 0 in any state: next state is IDLE. In SAMPLE, disable wins and there is no capture and no `o_frame`. `o_drv_sw` holds its last image.
- Re-enable always restarts at row 0 with a full settle period.
- Rows not yet rescanned keep their previous image contents; no partial-frame clearing.
- No ghosting or rollover logic; the image is raw, and debounce is done downstream.

## Timing
- Reset values (asynchronous on `i_rst` = 0):
  - state IDLE
  - `o_row` all R
  - `o_row_idx` = 0
  - `o_drv_sw` all R
  - `o_frame` = 0
  - synchronizer flops = R
- Reset mid-scan aborts immediately to these values, with no partial capture.
- The enable edge seen at clock k gives row 0 driven from cycle k+1.
- Row period = p_settle + 1 cycles.
- Frame period = p_line × (p_settle + 1) cycles.
- Key-to-image latency, `i_col` stable before the row's SAMPLE edge: ≤ frame period + 1 cycle.
- The sampled column value reflects `i_col` at least p_settle-2 cycles after the row drive changed.
- `o_frame` is high exactly one cycle per completed frame, coincident with the first cycle in which row `p_line-1` of the new image is visible.

## Test plan
- Reset/idle: hold `i_rst` = 0, then release with `i_en` = 0 and PULLUP, 4×4 -> `o_row` = 4'b1111, all `o_drv_sw` = 4'b1111, `o_frame` = 0 indefinitely.
- Scan order/period: PULLUP, 4×4, `p_settle` = 4, `i_en` = 1, `i_col` = 4'b1111 ->
  - `o_row` cycles 1110 → 1101 → 1011 → 0111, each held 5 cycles.
  - `o_frame` pulses every 20 cycles.
  - `o_row_idx` wraps 3 → 0.
- Single key: column model pulls col 1 low only while row 2 is driven -> after row-2 SAMPLE, `o_drv_sw[2]` = 4'b1101 and all other rows stay 4'b1111. After key release, `o_drv_sw[2]` returns to 4'b1111 within one frame.
- Disable mid-scan: deassert `i_en` during row 1 SAMPLE ->
  - no capture and no `o_frame`.
  - `o_row` = 1111 next cycle; image held.
  - Reassert `i_en`: row 0 is driven for the full 5 cycles first.
- Async reset mid-scan: pull `i_rst` low during row 3 SETTLE with keys in the image -> outputs go to reset values without waiting for a clock edge. The scan restarts at row 0 after release.
- PULLDOWN: `p_mode` = 1, key at [0][3] drives col 3 high when row 0 is high -> `o_row` idle = 0000, active row bit = 1, `o_drv_sw[0]` = 4'b1000.
